// File: rtl/spi_pkg.sv
// Shared SPI definitions: target FSM states and clock-edge selection helpers.
package spi_pkg;

    typedef enum logic {
        SPI_T_IDLE  = 1'b0,
        SPI_T_SHIFT = 1'b1
    } spi_t_state_e;

    localparam bit SPI_IDLE_LOW        = 1'b0;
    localparam bit SPI_IDLE_HIGH       = 1'b1;
    localparam bit SPI_SAMPLE_LEADING  = 1'b0;
    localparam bit SPI_SAMPLE_TRAILING = 1'b1;

    // Leading edge leaves the idle level: rising when idle low, falling when idle high.
    function automatic logic spi_leading_edge(input bit cpol, input logic rise, input logic fall);
        return (cpol == SPI_IDLE_HIGH) ? fall : rise;
    endfunction

    function automatic logic spi_trailing_edge(input bit cpol, input logic rise, input logic fall);
        return (cpol == SPI_IDLE_HIGH) ? rise : fall;
    endfunction

    function automatic logic spi_sample_edge(input bit cpol, input bit cpha,
                                             input logic rise, input logic fall);
        return (cpha == SPI_SAMPLE_TRAILING) ? spi_trailing_edge(cpol, rise, fall)
                                             : spi_leading_edge(cpol, rise, fall);
    endfunction

    function automatic logic spi_drive_edge(input bit cpol, input bit cpha,
                                            input logic rise, input logic fall);
        return (cpha == SPI_SAMPLE_TRAILING) ? spi_leading_edge(cpol, rise, fall)
                                             : spi_trailing_edge(cpol, rise, fall);
    endfunction

endpackage

// File: rtl/spi_target_if.sv
// Pad-side serial signals plus the local tx/rx client handshake of the SPI target.
interface spi_target_if #(
    parameter int unsigned SPI_WORD_LEN = 8
);
    logic                    SCLK_IN;
    logic                    SS_N_IN;
    logic                    MOSI_IN;
    logic                    MISO_OUT;
    logic                    MISO_OE;
    logic [SPI_WORD_LEN-1:0] tx_data;
    logic                    tx_valid;
    logic                    tx_ready;
    logic [SPI_WORD_LEN-1:0] rx_data;
    logic                    rx_valid;
    logic                    tx_underrun;
    logic                    busy;

    modport slave (
        input  SCLK_IN, SS_N_IN, MOSI_IN, tx_data, tx_valid,
        output MISO_OUT, MISO_OE, tx_ready, rx_data, rx_valid, tx_underrun, busy
    );

    modport master (
        output SCLK_IN, SS_N_IN, MOSI_IN, tx_data, tx_valid,
        input  MISO_OUT, MISO_OE, tx_ready, rx_data, rx_valid, tx_underrun, busy
    );
endinterface

// File: rtl/spi_sync_edge.sv
// Two-flop synchronizer for an asynchronous pin, plus one history flop for edge detection.
module spi_sync_edge #(
    parameter bit RESET_VALUE = 1'b0
) (
    input  logic master_clock,
    input  logic do_reset_n,
    input  logic async_in,
    output logic level,
    output logic rise,
    output logic fall
);
    // [0] metastable stage, [1] synchronized level, [2] previous synchronized level
    logic [2:0] sync_q;

    // Shift the pin through the synchronizer and history stages.
    always_ff @(posedge master_clock or negedge do_reset_n) begin
        if (!do_reset_n) begin
            sync_q <= {3{RESET_VALUE}};
        end else begin
            sync_q <= {sync_q[1:0], async_in};
        end
    end

    assign level = sync_q[1];
    assign rise  = sync_q[1] & ~sync_q[2];
    assign fall  = ~sync_q[1] & sync_q[2];
endmodule

// File: rtl/spi_target.sv
// SPI target endpoint: oversamples SCLK/SS_N/MOSI, shifts a buffered tx word out on MISO
// and assembles received bits into rx_data with a one-cycle rx_valid strobe.
module spi_target
    import spi_pkg::*;
#(
    parameter bit          CPOL              = 1'b0,
    parameter bit          CPHA              = 1'b0,
    parameter bit          INVERT_DATA_ORDER = 1'b0,
    parameter int unsigned SPI_WORD_LEN      = 8
) (
    input logic         master_clock,
    input logic         do_reset_n,
    spi_target_if.slave bus
);
    localparam int unsigned      IDX_W      = (SPI_WORD_LEN > 1) ? $clog2(SPI_WORD_LEN) : 1;
    localparam logic [IDX_W-1:0] FIRST_BIT  = INVERT_DATA_ORDER ? '0 : IDX_W'(SPI_WORD_LEN - 1);
    localparam logic [IDX_W-1:0] LAST_COUNT = IDX_W'(SPI_WORD_LEN - 1);

    logic sclk_level, sclk_rise, sclk_fall;
    logic ss_level, ss_rise, ss_fall;
    logic mosi_level, mosi_rise, mosi_fall;

    spi_sync_edge #(.RESET_VALUE(CPOL)) u_sync_sclk (
        .master_clock (master_clock),
        .do_reset_n   (do_reset_n),
        .async_in     (bus.SCLK_IN),
        .level        (sclk_level),
        .rise         (sclk_rise),
        .fall         (sclk_fall)
    );

    spi_sync_edge #(.RESET_VALUE(1'b1)) u_sync_ss (
        .master_clock (master_clock),
        .do_reset_n   (do_reset_n),
        .async_in     (bus.SS_N_IN),
        .level        (ss_level),
        .rise         (ss_rise),
        .fall         (ss_fall)
    );

    spi_sync_edge #(.RESET_VALUE(1'b0)) u_sync_mosi (
        .master_clock (master_clock),
        .do_reset_n   (do_reset_n),
        .async_in     (bus.MOSI_IN),
        .level        (mosi_level),
        .rise         (mosi_rise),
        .fall         (mosi_fall)
    );

    // Detector outputs this block has no use for.
    logic unused_sync;
    assign unused_sync = ^{sclk_level, ss_rise, mosi_rise, mosi_fall};

    spi_t_state_e            state_q;
    logic [SPI_WORD_LEN-1:0] tx_buf_q, tx_hold_q, rx_shift_q, rx_data_q, rx_next;
    logic                    tx_buf_full_q, miso_oe_q, rx_valid_q, tx_underrun_q;
    logic [IDX_W-1:0]        bit_index_q, sample_cnt_q, bit_index_adv;
    logic                    sample_edge, drive_edge, word_start, tx_accept;

    assign sample_edge = spi_sample_edge(CPOL, CPHA, sclk_rise, sclk_fall);
    assign drive_edge  = spi_drive_edge(CPOL, CPHA, sclk_rise, sclk_fall);
    assign tx_accept   = bus.tx_valid && !tx_buf_full_q;

    // Word start: SS_N fall for CPHA=0, else the first drive edge of a word (counter at 0).
    // A deselect in the same cycle as a drive edge suppresses the start.
    always_comb begin
        word_start = 1'b0;
        if (state_q == SPI_T_IDLE) begin
            word_start = !CPHA && ss_fall;
        end else begin
            word_start = drive_edge && (sample_cnt_q == '0) && !ss_level;
        end
    end

    // Received word with the current MOSI bit merged in, and the next bit position.
    always_comb begin
        rx_next              = rx_shift_q;
        rx_next[bit_index_q] = mosi_level;
        bit_index_adv        = INVERT_DATA_ORDER ? bit_index_q + IDX_W'(1)
                                                 : bit_index_q - IDX_W'(1);
    end

    // Control FSM, tx buffer, shift registers and registered strobes.
    always_ff @(posedge master_clock or negedge do_reset_n) begin
        if (!do_reset_n) begin
            state_q       <= SPI_T_IDLE;
            miso_oe_q     <= 1'b0;
            tx_buf_q      <= '0;
            tx_buf_full_q <= 1'b0;
            tx_hold_q     <= '0;
            bit_index_q   <= FIRST_BIT;
            sample_cnt_q  <= '0;
            rx_shift_q    <= '0;
            rx_data_q     <= '0;
            rx_valid_q    <= 1'b0;
            tx_underrun_q <= 1'b0;
        end else begin
            rx_valid_q    <= 1'b0;
            tx_underrun_q <= 1'b0;

            if (tx_accept) begin
                tx_buf_q <= bus.tx_data;
            end
            // The buffer is consumed before a same-cycle accept refills it.
            if (word_start) begin
                tx_hold_q     <= tx_buf_full_q ? tx_buf_q : '0;
                tx_underrun_q <= !tx_buf_full_q;
                tx_buf_full_q <= tx_accept;
            end else if (tx_accept) begin
                tx_buf_full_q <= 1'b1;
            end

            case (state_q)
                SPI_T_IDLE: begin
                    if (!ss_level) begin
                        state_q      <= SPI_T_SHIFT;
                        miso_oe_q    <= 1'b1;
                        sample_cnt_q <= '0;
                        bit_index_q  <= FIRST_BIT;
                    end
                end
                SPI_T_SHIFT: begin
                    if (word_start) begin
                        bit_index_q <= FIRST_BIT;
                    end else if (drive_edge) begin
                        bit_index_q <= bit_index_adv;
                    end
                    if (sample_edge) begin
                        rx_shift_q <= rx_next;
                        if (sample_cnt_q == LAST_COUNT) begin
                            rx_data_q    <= rx_next;
                            rx_valid_q   <= 1'b1;
                            sample_cnt_q <= '0;
                        end else begin
                            sample_cnt_q <= sample_cnt_q + IDX_W'(1);
                        end
                    end
                    // Deselect drops any partial word; a final sample this cycle still lands.
                    if (ss_level) begin
                        state_q      <= SPI_T_IDLE;
                        miso_oe_q    <= 1'b0;
                        sample_cnt_q <= '0;
                        bit_index_q  <= FIRST_BIT;
                    end
                end
                default: state_q <= SPI_T_IDLE;
            endcase
        end
    end

    assign bus.MISO_OUT    = miso_oe_q & tx_hold_q[bit_index_q];
    assign bus.MISO_OE     = miso_oe_q;
    assign bus.tx_ready    = !tx_buf_full_q;
    assign bus.rx_data     = rx_data_q;
    assign bus.rx_valid    = rx_valid_q;
    assign bus.tx_underrun = tx_underrun_q;
    assign bus.busy        = (state_q == SPI_T_SHIFT);
endmodule
